// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
//
// Provides a configurable reset vector and exception vector, a valid/ready
// fetch handshake, stall handling with a one-entry buffered redirect,
// trapping of misaligned redirect targets and capture of the exception PC.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous reset, active-high
//   stall            in   pipeline stall, freezes the PC
//   redirect_valid   in   branch/jump request
//   redirect_target  in   branch/jump destination
//   exception        in   trap request (single-cycle pulse)
//   fetch_ready      in   fetch stage accepts currentpc this cycle
//   currentpc        out  PC presented to fetch
//   pc_valid         out  currentpc is valid for fetch
//   pc_plus_inc      out  currentpc + INC (combinational, wraps)
//   epc              out  PC or bad target saved on a trap
//   misaligned       out  one-cycle pulse when a misaligned redirect traps
//   redirect_pending out  a buffered redirect is waiting
module pc_sequencer #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h80020000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80000180),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exception,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] currentpc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic [WIDTH-1:0] epc,
  output logic             misaligned,
  output logic             redirect_pending
);

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mis_q, mis_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [WIDTH-1:0] tgt;

  assign pc_plus_inc = pc_q + INC_W;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      mis_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      mis_q      <= mis_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Next-state: priority exception > stall > redirect > pending > advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    mis_d      = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    tgt        = redirect_target;
    case (state_q)
      TRAP: begin
        // One-cycle bubble; every request is dropped here.
        state_d = RUN;
      end
      default: begin
        if (exception) begin
          epc_d      = pc_q;
          pc_d       = EXC_VECTOR;
          pend_vld_d = 1'b0;
          state_d    = TRAP;
        end else if (stall) begin
          // Only RUN buffers redirects; BOOT drops them. Latest one wins.
          if (state_q == RUN && redirect_valid) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redirect_target;
          end
        end else if (state_q == RUN && (redirect_valid || pend_vld_q)) begin
          // A live redirect supersedes the buffered one; either way the
          // buffer is consumed. No fetch_ready needed: the fetch is squashed.
          tgt        = redirect_valid ? redirect_target : pend_tgt_q;
          pend_vld_d = 1'b0;
          if ((tgt & ALIGN_MASK) != '0) begin
            epc_d   = tgt;
            pc_d    = EXC_VECTOR;
            mis_d   = 1'b1;
            state_d = TRAP;
          end else begin
            pc_d = tgt;
          end
        end else if (fetch_ready) begin
          // pc_valid is always high outside TRAP, so this is the handshake.
          pc_d    = pc_plus_inc;
          state_d = RUN;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    pc_valid         = (state_q != TRAP);
    currentpc        = pc_q;
    epc              = epc_q;
    misaligned       = mis_q;
    redirect_pending = pend_vld_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h80020000;
  localparam logic [31:0] EXC = 32'h80000180;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, exception, fetch_ready;
  logic [31:0] redirect_target;
  logic [31:0] currentpc, pc_plus_inc, epc;
  logic        pc_valid, misaligned, redirect_pending;

  int n_pass  = 0;
  int n_total = 0;

  pc_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .exception        (exception),
    .fetch_ready      (fetch_ready),
    .currentpc        (currentpc),
    .pc_valid         (pc_valid),
    .pc_plus_inc      (pc_plus_inc),
    .epc              (epc),
    .misaligned       (misaligned),
    .redirect_pending (redirect_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          st, rv, ex, fr;
    logic [31:0] tgt;
    logic [31:0] pc;
    bit          vld;
    logic [31:0] epc;
    bit          mis;
    bit          pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit st, bit rv, logic [31:0] tgt, bit ex, bit fr,
                              logic [31:0] pc, bit vld, logic [31:0] e, bit mis, bit pend);
    vec_t v;
    v.st = st; v.rv = rv; v.tgt = tgt; v.ex = ex; v.fr = fr;
    v.pc = pc; v.vld = vld; v.epc = e; v.mis = mis; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input bit vld,
                         input logic [31:0] e, input bit mis, input bit pend);
    chk({tag, ".pc"},   currentpc, pc);
    chk({tag, ".inc"},  pc_plus_inc, pc + 32'd4);
    chk({tag, ".vld"},  {31'd0, pc_valid}, {31'd0, vld});
    chk({tag, ".epc"},  epc, e);
    chk({tag, ".mis"},  {31'd0, misaligned}, {31'd0, mis});
    chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, pend});
  endtask

  task automatic drive(input bit st, input bit rv, input logic [31:0] tgt, input bit ex, input bit fr);
    stall = st; redirect_valid = rv; redirect_target = tgt; exception = ex; fetch_ready = fr;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Behavioural reference: mode 0=boot 1=run 2=trap, pending held in a queue
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  bit          m_mis;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_mode = 0; m_pc = RV; m_epc = 0; m_mis = 0; m_pend.delete();
  endtask

  task automatic model_step(input bit st, input bit rv, input logic [31:0] tg, input bit ex, input bit fr);
    logic [31:0] dest;
    m_mis = 0;
    if (m_mode == 2) begin
      m_mode = 1;
      return;
    end
    if (ex) begin
      m_epc = m_pc; m_pc = EXC; m_pend.delete(); m_mode = 2;
      return;
    end
    if (st) begin
      if (m_mode == 1 && rv) begin
        m_pend.delete();
        m_pend.push_back(tg);
      end
      return;
    end
    if (m_mode == 1 && (rv || m_pend.size() != 0)) begin
      dest = rv ? tg : m_pend[0];
      m_pend.delete();
      if (dest % 4 != 0) begin
        m_epc = dest; m_pc = EXC; m_mis = 1; m_mode = 2;
      end else begin
        m_pc = dest;
      end
      return;
    end
    if (fr) begin
      m_pc = m_pc + 32'd4;
      m_mode = 1;
    end
  endtask

  initial begin
    logic [31:0] t;
    bit st, rv, ex, fr;
    int r;

    // Directed vectors, applied from reset release onward
    tbl.push_back(mk(0,0,0,0,1, 32'h80020004,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h80020008,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h8002000C,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h80020010,1,0,0,0));
    tbl.push_back(mk(0,1,32'h80021000,0,0, 32'h80021000,1,0,0,0));
    tbl.push_back(mk(1,1,32'h80030000,0,1, 32'h80021000,1,0,0,1));
    tbl.push_back(mk(1,1,32'h80040000,0,0, 32'h80021000,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,1, 32'h80040000,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h80040000,1,0,0,0));
    tbl.push_back(mk(0,1,32'h80021002,0,0, EXC,0,32'h80021002,1,0));
    tbl.push_back(mk(0,0,0,0,1, EXC,1,32'h80021002,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h80000184,1,32'h80021002,0,0));
    tbl.push_back(mk(0,1,32'h80020020,0,0, 32'h80020020,1,32'h80021002,0,0));
    tbl.push_back(mk(1,0,0,1,0, EXC,0,32'h80020020,0,0));
    tbl.push_back(mk(1,0,0,0,1, EXC,1,32'h80020020,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h80000184,1,32'h80020020,0,0));
    tbl.push_back(mk(0,1,32'h80000184,0,0, 32'h80000184,1,32'h80020020,0,0));
    tbl.push_back(mk(0,0,0,1,1, EXC,0,32'h80000184,0,0));
    tbl.push_back(mk(0,1,32'h80012340,1,1, EXC,1,32'h80000184,0,0));
    tbl.push_back(mk(1,1,32'h80050000,0,1, EXC,1,32'h80000184,0,1));
    tbl.push_back(mk(0,1,32'h80060000,0,1, 32'h80060000,1,32'h80000184,0,0));
    tbl.push_back(mk(1,1,32'h80070001,0,0, 32'h80060000,1,32'h80000184,0,1));
    tbl.push_back(mk(0,0,0,0,1, EXC,0,32'h80070001,1,0));
    tbl.push_back(mk(0,0,0,0,1, EXC,1,32'h80070001,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h80000184,1,32'h80070001,0,0));
    tbl.push_back(mk(1,1,32'h80050000,0,0, 32'h80000184,1,32'h80070001,0,1));
    tbl.push_back(mk(1,0,0,1,0, EXC,0,32'h80000184,0,0));
    tbl.push_back(mk(0,0,0,0,0, EXC,1,32'h80000184,0,0));
    tbl.push_back(mk(0,0,0,0,0, EXC,1,32'h80000184,0,0));

    reset = 1'b1;
    drive(0,0,0,0,0);
    #12;
    chk_all("reset", RV, 1, 0, 0, 0);
    cycle();
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].rv, tbl[i].tgt, tbl[i].ex, tbl[i].fr);
      cycle();
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].vld, tbl[i].epc, tbl[i].mis, tbl[i].pend);
    end

    // Wrap-around at the top of the address space
    drive(0,1,32'hFFFFFFFC,0,0);
    cycle();
    chk("wrap.pc", currentpc, 32'hFFFFFFFC);
    chk("wrap.inc", pc_plus_inc, 32'h00000000);
    drive(0,0,0,0,1);
    cycle();
    chk("wrap.adv", currentpc, 32'h00000000);

    // Reset asserted mid-stall with a redirect pending: takes effect at once
    drive(1,1,32'h80080000,0,1);
    cycle();
    chk("midrst.pend_before", {31'd0, redirect_pending}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk_all("midrst", RV, 1, 0, 0, 0);
    cycle();
    reset = 1'b0;

    // BOOT ignores redirects, stalled or not, and does not buffer them
    drive(0,1,32'h80090000,0,0);
    cycle();
    chk_all("boot.rv", RV, 1, 0, 0, 0);
    drive(1,1,32'h800A0000,0,1);
    cycle();
    chk_all("boot.stall_rv", RV, 1, 0, 0, 0);
    drive(0,0,0,0,1);
    cycle();
    chk_all("boot.adv", RV + 32'd4, 1, 0, 0, 0);

    // Randomised run against the reference model
    reset = 1'b1;
    drive(0,0,0,0,0);
    #2;
    model_reset();
    cycle();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 4) == 0);
      ex = ($urandom_range(0, 19) == 0);
      fr = ($urandom_range(0, 9) < 7);
      r  = $urandom_range(0, 9);
      if (r == 0)      t = m_pc;
      else if (r == 1) t = $urandom | 32'h1;
      else             t = $urandom & 32'hFFFFFFFC;
      drive(st, rv, t, ex, fr);
      model_step(st, rv, t, ex, fr);
      cycle();
      if (currentpc !== m_pc || pc_valid !== (m_mode != 2) || epc !== m_epc ||
          misaligned !== m_mis || redirect_pending !== (m_pend.size() != 0) ||
          pc_plus_inc !== m_pc + 32'd4 || n % 100 == 0)
        chk_all($sformatf("rnd%0d", n), m_pc, (m_mode != 2), m_epc, m_mis, (m_pend.size() != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
